// File: rtl/fill_span_writer.sv
// Span writer for the polygon fill path: streams one pixel per accepted cycle across each row's
// span and tracks row progress. Optional macro FILL_SPAN_CLIP_EN clips spans to a 640x480 screen.
module fill_span_writer (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        math_done,
   input  logic [9:0]  y_start,
   input  logic [9:0]  y_end,
   input  logic [23:0] fill_color,
   input  logic        row_start,
   input  logic [9:0]  x_left,
   input  logic [9:0]  x_right,
   input  logic        fill_start,
   input  logic        wr_ready,
   output logic        wr_en,
   output logic [9:0]  wr_x,
   output logic [9:0]  wr_y,
   output logic [23:0] wr_color,
   output logic        fill_done,
   output logic        all_finish,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StWrite, StFdone} state_e;

   state_e      state_q, state_d;
   logic [9:0]  cur_y_q, cur_y_d;
   logic [9:0]  last_y_q, last_y_d;
   logic [23:0] col_q, col_d;
   logic [9:0]  xa_q, xa_d;
   logic [9:0]  xb_q, xb_d;
   logic [9:0]  xe_q, xe_d;
   logic [9:0]  cur_x_q, cur_x_d;
   logic        all_finish_q, all_finish_d;

   logic [9:0]  xs_c, xe_c;
   logic        skip_c;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= StIdle;
         cur_y_q      <= '0;
         last_y_q     <= '0;
         col_q        <= '0;
         xa_q         <= '0;
         xb_q         <= '0;
         xe_q         <= '0;
         cur_x_q      <= '0;
         all_finish_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_y_q      <= cur_y_d;
         last_y_q     <= last_y_d;
         col_q        <= col_d;
         xa_q         <= xa_d;
         xb_q         <= xb_d;
         xe_q         <= xe_d;
         cur_x_q      <= cur_x_d;
         all_finish_q <= all_finish_d;
      end
   end

   // Span bounds come from the most recently captured edge pair, in either order.
   always_comb begin
      xs_c   = (xa_q < xb_q) ? xa_q : xb_q;
      xe_c   = (xa_q < xb_q) ? xb_q : xa_q;
      skip_c = 1'b0;
`ifdef FILL_SPAN_CLIP_EN
      if (xs_c > 10'd639) xs_c = 10'd639;
      if (xe_c > 10'd639) xe_c = 10'd639;
      skip_c = (cur_y_q > 10'd479);
`endif
   end

   always_comb begin
      state_d      = state_q;
      cur_y_d      = cur_y_q;
      last_y_d     = last_y_q;
      col_d        = col_q;
      xa_d         = xa_q;
      xb_d         = xb_q;
      xe_d         = xe_q;
      cur_x_d      = cur_x_q;
      all_finish_d = all_finish_q;

      if (row_start) begin
         xa_d = x_left;
         xb_d = x_right;
      end

      case (state_q)
         StIdle: begin
            if (math_done) begin
               cur_y_d      = y_start;
               last_y_d     = y_end;
               col_d        = fill_color;
               // An empty y range is finished as soon as it is loaded.
               all_finish_d = (y_start > y_end);
            end
            if (fill_start) begin
               cur_x_d = xs_c;
               xe_d    = xe_c;
               state_d = skip_c ? StFdone : StWrite;
            end
         end
         StWrite: begin
            if (wr_ready) begin
               if (cur_x_q == xe_q) state_d = StFdone;
               else                 cur_x_d = cur_x_q + 10'd1;
            end
         end
         StFdone: begin
            state_d = StIdle;
            if (cur_y_q == last_y_q) all_finish_d = 1'b1;
            else                     cur_y_d      = cur_y_q + 10'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_en      = (state_q == StWrite);
   assign wr_x       = cur_x_q;
   assign wr_y       = cur_y_q;
   assign wr_color   = col_q;
   assign fill_done  = (state_q == StFdone);
   assign all_finish = all_finish_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fill_span_writer.sv
// Bench for fill_span_writer: expected-pixel queue model checked every cycle, randomized spans
// and handshake, plus directed scenarios with literal expectations.
module tb_fill_span_writer;

   logic        clk = 1'b0, n_rst = 1'b0;
   logic        math_done = 1'b0, row_start = 1'b0, fill_start = 1'b0, wr_ready = 1'b0;
   logic [9:0]  y_start = '0, y_end = '0, x_left = '0, x_right = '0;
   logic [23:0] fill_color = '0;
   logic        wr_en, fill_done, all_finish, busy;
   logic [9:0]  wr_x, wr_y;
   logic [23:0] wr_color;

   fill_span_writer dut (
      .clk(clk), .n_rst(n_rst), .math_done(math_done), .y_start(y_start), .y_end(y_end),
      .fill_color(fill_color), .row_start(row_start), .x_left(x_left), .x_right(x_right),
      .fill_start(fill_start), .wr_ready(wr_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_color(wr_color), .fill_done(fill_done), .all_finish(all_finish), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; int c;} pix_t;

   int   n_cmp = 0, n_bad = 0;
   pix_t exp_q[$];
   int   log_x[$], log_y[$];
   int   wr_cycles = 0, rdy_mode = 0, stall_left = 0;
   bit   mon_en = 1'b0;
   int   m_cur_y = 0, m_last = 0, m_col = 0;
   bit   m_all = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: a visible write must match the head of the expected queue; it pops on accept.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (wr_en) begin
            wr_cycles++;
            if (exp_q.size() == 0) check("spurious_wr_en", 32'(wr_en), 32'd0);
            else begin
               check("wr_x", 32'(wr_x), 32'(exp_q[0].x));
               check("wr_y", 32'(wr_y), 32'(exp_q[0].y));
               check("wr_color", 32'(wr_color), 32'(exp_q[0].c));
            end
         end
         case (rdy_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = ($urandom_range(3) != 0);
            default: begin
               if (wr_en && log_x.size() == 1 && stall_left > 0) begin
                  wr_ready = 1'b0;
                  stall_left--;
               end else wr_ready = 1'b1;
            end
         endcase
         if (wr_en && wr_ready) begin
            log_x.push_back(int'(wr_x));
            log_y.push_back(int'(wr_y));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_frame(input int ys, input int ye, input int c);
      @(posedge clk); #1;
      math_done = 1'b1; y_start = 10'(ys); y_end = 10'(ye); fill_color = 24'(c);
      @(posedge clk); #1;
      math_done = 1'b0;
      m_cur_y = ys; m_last = ye; m_col = c; m_all = (ys > ye);
      @(negedge clk);
      check("all_finish_after_math_done", 32'(all_finish), 32'(m_all));
      check("busy_idle_after_math_done", 32'(busy), 32'd0);
   endtask

   task automatic start_span(input int xl, input int xr);
      int lo, hi;
      bit skip;
      @(posedge clk); #1;
      row_start = 1'b1; x_left = 10'(xl); x_right = 10'(xr);
      @(posedge clk); #1;
      row_start = 1'b0; fill_start = 1'b1;
      lo = (xl < xr) ? xl : xr;
      hi = (xl < xr) ? xr : xl;
      skip = 1'b0;
`ifdef FILL_SPAN_CLIP_EN
      if (lo > 639) lo = 639;
      if (hi > 639) hi = 639;
      skip = (m_cur_y > 479);
`endif
      log_x.delete(); log_y.delete(); wr_cycles = 0;
      if (!skip) for (int x = lo; x <= hi; x++) exp_q.push_back('{x, m_cur_y, m_col});
      @(posedge clk); #1;
      fill_start = 1'b0;
   endtask

   task automatic finish_span(input int n_exp);
      bit got = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
         @(negedge clk);
         if (fill_done) got = 1'b1;
      end
      check("fill_done_seen", 32'(got), 32'd1);
      check("pixels_outstanding", 32'(exp_q.size()), 32'd0);
      check("span_pixel_count", 32'(log_x.size()), 32'(n_exp));
      check("busy_in_fdone", 32'(busy), 32'd1);
      exp_q.delete();
      @(negedge clk);
      check("fill_done_one_cycle", 32'(fill_done), 32'd0);
      if (m_cur_y == m_last) m_all = 1'b1;
      else m_cur_y++;
      check("all_finish_after_span", 32'(all_finish), 32'(m_all));
      check("busy_back_idle", 32'(busy), 32'd0);
   endtask

   task automatic do_span(input int xl, input int xr);
      int n;
      start_span(xl, xr);
      n = exp_q.size();
      finish_span(n);
   endtask

   initial begin
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_all_finish", 32'(all_finish), 32'd0);
      check("rst_fill_done", 32'(fill_done), 32'd0);
      check("rst_wr_xy", {12'd0, wr_x, wr_y}, 32'd0);
      check("rst_wr_color", 32'(wr_color), 32'd0);
      #22 n_rst = 1'b1;
      mon_en = 1'b1;

      // Single-row span at full throughput.
      rdy_mode = 0;
      do_frame(10, 10, 24'h12abcd);
      do_span(5, 8);
      check("lit_span_5_8_len", 32'(log_x.size()), 32'd4);
      if (log_x.size() == 4) begin
         check("lit_first_x", 32'(log_x[0]), 32'd5);
         check("lit_last_x", 32'(log_x[3]), 32'd8);
         check("lit_row_y", 32'(log_y[0]), 32'd10);
      end
      check("lit_consecutive_cycles", 32'(wr_cycles), 32'd4);
      check("lit_all_finish_single", 32'(all_finish), 32'd1);

      // Reversed edge order.
      do_frame(2, 2, 24'h00ff00);
      do_span(20, 17);
      if (log_x.size() == 4) begin
         check("lit_rev_x0", 32'(log_x[0]), 32'd17);
         check("lit_rev_x3", 32'(log_x[3]), 32'd20);
      end else check("lit_rev_len", 32'(log_x.size()), 32'd4);

      // Three-cycle stall on the 2nd pixel.
      rdy_mode = 2; stall_left = 3;
      do_frame(40, 40, 24'h777777);
      do_span(30, 34);
      check("lit_stall_cycles", 32'(wr_cycles), 32'd8);
      if (log_x.size() == 5) check("lit_stall_x1", 32'(log_x[1]), 32'd31);
      rdy_mode = 0;

      // Three rows; all_finish only after the last.
      do_frame(3, 5, 24'h0a0b0c);
      for (int k = 0; k < 3; k++) begin
         do_span(100 + k, 102);
         if (log_y.size() > 0) check("lit_row_y_seq", 32'(log_y[0]), 32'(3 + k));
         check("lit_row_all_finish", 32'(all_finish), 32'(k == 2));
      end

      // Empty y range.
      do_frame(9, 4, 24'h111111);
      check("lit_empty_range_finish", 32'(all_finish), 32'd1);
      repeat (4) @(negedge clk);

      // Randomized frames and handshake.
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) begin
         int ys, ye, xl, xr;
         ys = int'($urandom_range(0, 30));
         ye = ys + int'($urandom_range(0, 3));
         do_frame(ys, ye, int'($urandom & 32'hffffff));
         for (int r = ys; r <= ye; r++) begin
            xl = int'($urandom_range(0, 1023));
            xr = xl + int'($urandom_range(0, 24)) - 12;
            if (xr < 0) xr = 0;
            if (xr > 1023) xr = 1023;
            do_span(xl, xr);
         end
      end

      // Asynchronous reset in the middle of a span while all_finish is held high.
      do_frame(100, 100, 24'habcdef);
      do_span(1, 2);
      start_span(0, 200);
      repeat (10) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      check("pre_reset_all_finish", 32'(all_finish), 32'd1);
      #2 mon_en = 1'b0; n_rst = 1'b0;
      #1;
      check("mid_reset_wr_en", 32'(wr_en), 32'd0);
      check("mid_reset_busy", 32'(busy), 32'd0);
      check("mid_reset_all_finish", 32'(all_finish), 32'd0);
      check("mid_reset_wr_x", 32'(wr_x), 32'd0);
      exp_q.delete();
      #3 n_rst = 1'b1;
      mon_en = 1'b1;
      rdy_mode = 0;
      do_frame(7, 8, 24'h445566);
      do_span(3, 3);
      check("lit_restart_single_px", 32'(log_x.size()), 32'd1);
      do_span(9, 6);
      check("lit_restart_finish", 32'(all_finish), 32'd1);

`ifdef FILL_SPAN_CLIP_EN
      do_frame(20, 20, 24'h010203);
      do_span(630, 700);
      if (log_x.size() > 0) check("lit_clip_last_x", 32'(log_x[log_x.size() - 1]), 32'd639);
      check("lit_clip_len", 32'(log_x.size()), 32'd10);
      do_frame(500, 500, 24'h010203);
      do_span(1, 3);
      check("lit_clip_offscreen_len", 32'(log_x.size()), 32'd0);
`else
      do_frame(600, 600, 24'h010203);
      do_span(1023, 1020);
      if (log_x.size() > 0) check("lit_noclip_last_x", 32'(log_x[log_x.size() - 1]), 32'd1023);
      check("lit_noclip_len", 32'(log_x.size()), 32'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule
